if_fetch: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline. Generates the program counter, issues word fetches to instruction memory over a request/grant/response handshake, and buffers returned instructions in a 2-entry fetch queue. Queue head drives `if_pc`/`if_inst` into `pipe_if_id`. Raises `stallreq_if` to the stall controller when no instruction is available, and redirects on taken branches from ID.

---
 rtl/if_fetch.sv | 120 ++++++++++++
 tb/tb_if_fetch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, single-outstanding imem request/grant/response
// handshake, and a 2-entry fetch queue whose head feeds the IF/ID register.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        br,
  input  logic [31:0] br_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned QD = 2;
  localparam int unsigned CW = 2;

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] req_pc_q, req_pc_d;
  logic [AW-1:0] qpc_q [QD];
  logic [AW-1:0] qpc_d [QD];
  logic [DW-1:0] qinst_q [QD];
  logic [DW-1:0] qinst_d [QD];
  logic [CW-1:0] cnt_q, cnt_d, cnt_mid;
  logic          outst_q, outst_d;
  logic          drop_q, drop_d;

  logic br_take, consume, resp_done, push, space, grant, empty;
  logic unused_stall;

  assign unused_stall = ^{stall[5:3], stall[0]};

  // Handshake and queue-control terms
  assign empty     = (cnt_q == '0);
  assign br_take   = br & ~stall[2];
  assign consume   = ~empty & ~stall[1] & ~br_take;
  assign resp_done = outst_q & imem_rvalid;
  assign push      = resp_done & ~drop_q & ~br_take;
  assign space     = (cnt_q - CW'(consume) + CW'(resp_done & ~drop_q)) <= CW'(1);
  assign imem_req  = ~rst & ~br_take & (~outst_q | resp_done) & space;
  assign grant     = imem_req & imem_gnt;
  assign imem_addr = pc_q;

  // Head of queue drives the pipeline; reset masks any stale contents
  assign stallreq_if = rst | empty;
  assign if_pc       = stallreq_if ? '0 : qpc_q[0];
  assign if_inst     = stallreq_if ? NOP_INST : qinst_q[0];

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    qpc_d    = qpc_q;
    qinst_d  = qinst_q;
    cnt_mid  = cnt_q - CW'(consume);

    if (consume) begin
      qpc_d[0]   = qpc_q[1];
      qinst_d[0] = qinst_q[1];
    end
    // Push lands behind whatever survives the pop, so order is preserved
    if (push) begin
      qpc_d[cnt_mid[0]]   = req_pc_q;
      qinst_d[cnt_mid[0]] = imem_rdata;
    end
    cnt_d = cnt_mid + CW'(push);

    if (resp_done) begin
      outst_d = 1'b0;
    end

    if (br_take) begin
      cnt_d = '0;
      pc_d  = br_addr;
      if (outst_q & ~imem_rvalid) begin
        drop_d = 1'b1;
      end
    end else if (grant) begin
      pc_d     = pc_q + AW'(4);
      outst_d  = 1'b1;
      req_pc_d = pc_q;
      drop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
      cnt_q    <= '0;
      outst_q  <= 1'b0;
      drop_q   <= 1'b0;
      for (int unsigned i = 0; i < QD; i++) begin
        qpc_q[i]   <= '0;
        qinst_q[i] <= '0;
      end
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      cnt_q    <= cnt_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      for (int unsigned i = 0; i < QD; i++) begin
        qpc_q[i]   <= qpc_d[i];
        qinst_q[i] <= qinst_d[i];
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: latency-configurable imem responder, transaction-level queue model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        br;
  logic [31:0] br_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stallreq_if;

  if_fetch #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br(br), .br_addr(br_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .stallreq_if(stallreq_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          live;
    bit          orphan;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  mreq_t       mq[$];
  ent_t        mdl[$];
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] key = 32'h0;
  logic [31:0] exp_fetch = RST_PC;
  logic [31:0] exp_cons  = RST_PC;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  // Memory: answers each grant `lat` cycles later with addr ^ key
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (mq.size() > 0 && mq[0].due == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq[0].addr ^ key;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic model_step();
    bit btake, cons, rdone, rlive, outst, ereq;
    int sz;
    if (rst) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_stallreq", 32'(stallreq_if), 32'd1);
      chk("rst_if_pc", if_pc, 32'd0);
      chk("rst_if_inst", if_inst, NOP);
      foreach (mq[i]) mq[i].orphan = 1'b1;
      if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
      mdl.delete();
      exp_fetch = RST_PC;
      exp_cons  = RST_PC;
      return;
    end
    sz = mdl.size();
    chk("stallreq_if", 32'(stallreq_if), 32'(sz == 0));
    if (sz == 0) begin
      chk("if_pc_empty", if_pc, 32'd0);
      chk("if_inst_empty", if_inst, NOP);
    end else begin
      chk("if_pc", if_pc, mdl[0].pc);
      chk("if_inst", if_inst, mdl[0].inst);
    end
    btake = br & ~stall[2];
    cons  = (sz != 0) && !stall[1] && !btake;
    rdone = imem_rvalid && mq.size() > 0 && !mq[0].orphan;
    rlive = rdone && mq[0].live;
    outst = 1'b0;
    foreach (mq[i]) if (!mq[i].orphan) outst = 1'b1;
    ereq = !btake && (!outst || rdone) && ((sz - int'(cons) + int'(rlive)) <= 1);
    chk("imem_req", 32'(imem_req), 32'(ereq));
    if (imem_req) chk("imem_addr", imem_addr, exp_fetch);
    if (cons) begin
      chk("program_order", if_pc, exp_cons);
      exp_cons = exp_cons + 32'd4;
      void'(mdl.pop_front());
    end
    if (imem_rvalid && mq.size() > 0) begin
      if (rlive && !btake) mdl.push_back('{mq[0].addr, imem_rdata});
      void'(mq.pop_front());
    end
    if (btake) begin
      mdl.delete();
      foreach (mq[i]) mq[i].live = 1'b0;
      exp_fetch = br_addr;
      exp_cons  = br_addr;
    end
    if (imem_req && imem_gnt) begin
      mq.push_back('{imem_addr, cyc + lat, 1'b1, 1'b0});
      exp_fetch = exp_fetch + 32'd4;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      neg();
    end
  endtask

  // Waits (bounded) for the first valid head and pins it to a literal
  task automatic expect_head(input string nm, input logic [31:0] pc);
    bit found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!stallreq_if) begin
        found = 1'b1;
        break;
      end
      tick();
      neg();
    end
    if (!found) timeout(nm);
    else begin
      chk({nm, "_pc"}, if_pc, pc);
      chk({nm, "_inst"}, if_inst, pc ^ key);
    end
  endtask

  task automatic drain();
    bit found = 1'b0;
    imem_gnt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 0) begin
        found = 1'b1;
        break;
      end
      tick();
      neg();
    end
    if (!found) timeout("drain");
  endtask

  task automatic wait_grant(input string nm, input bit any, input logic [31:0] addr);
    bit found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      neg();
      if (imem_req && imem_gnt && (any || imem_addr == addr)) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) timeout(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  logic [31:0] held_pc, a0, p0;
  bit          found;

  initial begin
    rst = 1'b1; stall = 6'b0; br = 1'b0; br_addr = 32'h0; imem_gnt = 1'b1;
    tick(); tick();
    neg();
    chk("reset_req", 32'(imem_req), 32'd0);
    chk("reset_stallreq", 32'(stallreq_if), 32'd1);
    chk("reset_if_inst", if_inst, NOP);

    // 1-cycle memory, data == address
    tick(); rst = 1'b0;
    neg(); chk("t1_addr_c0", imem_addr, 32'h0); chk("t1_req_c0", 32'(imem_req), 32'd1);
    tick(); neg(); chk("t1_addr_c1", imem_addr, 32'h4);
    tick(); neg(); chk("t1_inst_c2", if_inst, 32'h0); chk("t1_pc_c2", if_pc, 32'h0);
    chk("t1_addr_c2", imem_addr, 32'h8);
    tick(); neg(); chk("t1_inst_c3", if_inst, 32'h4);
    tick(); neg(); chk("t1_inst_c4", if_inst, 32'h8);
    for (int i = 0; i < 6; i++) begin
      tick(); neg(); chk("t1_no_stall", 32'(stallreq_if), 32'd0);
    end

    // IF/ID hold for 5 cycles
    tick(); stall = 6'b000010;
    neg(); held_pc = if_pc;
    run(4);
    chk("t2_req_off", 32'(imem_req), 32'd0);
    chk("t2_head_held", if_pc, held_pc);
    chk("t2_not_empty", 32'(stallreq_if), 32'd0);
    tick(); stall = 6'b0;
    neg();
    run(8);

    // 3-cycle response latency
    key = 32'h5A5A_0000;
    lat = 3;
    run(30);

    // Branch while request for 0x10 is outstanding
    drain();
    tick(); rst = 1'b1;
    tick(); tick(); rst = 1'b0; imem_gnt = 1'b1;
    wait_grant("t4_grant_0x10", 1'b0, 32'h10);
    tick(); br = 1'b1; br_addr = 32'h100;
    neg(); chk("t4_req_in_br", 32'(imem_req), 32'd0);
    tick(); br = 1'b0;
    neg(); chk("t4_addr_target", imem_addr, 32'h100);
    expect_head("t4_head", 32'h100);
    run(10);

    // Branch in the same cycle as a response
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      neg();
      if (mq.size() > 0 && mq[0].due == cyc + 1 && !mq[0].orphan && mq[0].live) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    if (!found) timeout("t5_find_rsp");
    tick(); br = 1'b1; br_addr = 32'h200;
    neg(); chk("t5_req_in_br", 32'(imem_req), 32'd0);
    tick(); br = 1'b0;
    neg();
    expect_head("t5_head", 32'h200);

    // Branch while ID is held is ignored
    lat = 1;
    run(10);
    a0 = imem_addr;
    p0 = if_pc;
    tick(); stall = 6'b000100; br = 1'b1; br_addr = 32'h300;
    neg();
    chk("t6_addr_seq", imem_addr, a0 + 32'd4);
    chk("t6_head_seq", if_pc, p0 + 32'd4);
    tick(); stall = 6'b0; br = 1'b0;
    neg();
    run(8);

    // Reset while waiting on a response; stale rvalid must be ignored
    lat = 3;
    wait_grant("t7_grant", 1'b1, 32'h0);
    tick(); rst = 1'b1; imem_gnt = 1'b0;
    neg();
    tick(); rst = 1'b0;
    neg();
    chk("t7_addr_restart", imem_addr, RST_PC);
    chk("t7_req_restart", 32'(imem_req), 32'd1);
    tick(); neg(); chk("t7_stale_ignored", 32'(stallreq_if), 32'd1);
    tick(); neg(); chk("t7_still_empty", 32'(stallreq_if), 32'd1);
    chk("t7_addr_stable", imem_addr, RST_PC);
    tick(); imem_gnt = 1'b1;
    neg();
    expect_head("t7_head", RST_PC);

    // Grant withheld every other cycle
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      tick(); imem_gnt = ~imem_gnt;
      neg();
    end
    tick(); imem_gnt = 1'b1;
    neg();
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
